vertex_transform: RTL

Streaming 4x4 fixed-point matrix × homogeneous-vertex transform unit for the 3D pipeline. It sits between vertex fetch and the projection/rasteriser stages and generalises the single-shot position transform with three additions: parametrised word width and fraction, a loadable double-buffered matrix, and ready/valid backpressure. It accepts one vertex per cycle and returns the result after a fixed 3-cycle latency, with saturation flags.

---
 rtl/vertex_transform_pkg.sv | 27 ++
 rtl/vertex_transform_if.sv | 28 ++
 rtl/vertex_transform_dot4.sv | 68 ++++++
 rtl/vertex_transform.sv | 104 ++++++++++
 4 files changed

// File: rtl/vertex_transform_pkg.sv
// Shared lane indices, fixed-point helpers and the 4x4 matrix type for the vertex transform.
package transform_pkg;

  localparam int unsigned X_L = 3;
  localparam int unsigned Y_L = 2;
  localparam int unsigned Z_L = 1;
  localparam int unsigned W_L = 0;

  // Widest element the matrix type carries; users slice down to their own WIDTH.
  localparam int unsigned MAX_WIDTH = 64;

  typedef logic signed [3:0][3:0][MAX_WIDTH-1:0] mat4_t;

  function automatic logic [MAX_WIDTH-1:0] fx_one(input int unsigned frac);
    return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << frac;
  endfunction

  function automatic mat4_t mat4_identity(input int unsigned frac);
    mat4_t m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[2'(i)][2'(i)] = fx_one(frac);
    end
    return m;
  endfunction

endpackage

// File: rtl/vertex_transform_if.sv
// Vertex stream, result stream and matrix-load signals of the vertex transform unit.
interface vertex_transform_if #(
  parameter int WIDTH = 32
);

  logic signed [WIDTH-1:0] pos     [3:0];
  logic                    v_in;
  logic                    ready_in;
  logic signed [WIDTH-1:0] new_pos [3:0];
  logic                    v_out;
  logic                    ready_out;
  logic        [3:0]       sat_out;
  logic                    m_we;
  logic        [3:0]       m_addr;
  logic        [WIDTH-1:0] m_data;
  logic                    m_commit;

  modport master (
    output pos, v_in, ready_out, m_we, m_addr, m_data, m_commit,
    input  ready_in, new_pos, v_out, sat_out
  );

  modport slave (
    input  pos, v_in, ready_out, m_we, m_addr, m_data, m_commit,
    output ready_in, new_pos, v_out, sat_out
  );

endinterface

// File: rtl/vertex_transform_dot4.sv
// One output row: registered products, registered pair sums, then row sum, shift and clamp.
module vertex_dot4 #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] row    [3:0],
  input  logic signed [WIDTH-1:0] lane   [3:0],
  output logic signed [WIDTH-1:0] result,
  output logic                    sat
);

  localparam int PW  = 2 * WIDTH;
  localparam int SW1 = PW + 1;
  localparam int SW  = PW + 2;

  localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0]  prod [3:0];
  logic signed [SW1-1:0] pair [1:0];
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  shifted;
  logic                  over;
  logic                  under;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < 4; c++) begin
        prod[2'(c)] <= '0;
      end
      pair[0] <= '0;
      pair[1] <= '0;
    end else if (enable) begin
      for (int unsigned c = 0; c < 4; c++) begin
        prod[2'(c)] <= PW'(row[2'(c)]) * PW'(lane[2'(c)]);
      end
      pair[0] <= SW1'(prod[0]) + SW1'(prod[1]);
      pair[1] <= SW1'(prod[2]) + SW1'(prod[3]);
    end
  end

  always_comb begin
    sum     = SW'(pair[0]) + SW'(pair[1]);
    shifted = sum >>> FRAC;
    over    = shifted > MAXV;
    under   = shifted < MINV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      sat    <= 1'b0;
    end else if (enable) begin
      if (over) begin
        result <= {1'b0, {(WIDTH-1){1'b1}}};
      end else if (under) begin
        result <= {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        result <= shifted[WIDTH-1:0];
      end
      sat <= over || under;
    end
  end

endmodule

// File: rtl/vertex_transform.sv
// Streaming 4x4 matrix x vertex transform: double-buffered matrix, 3-stage pipeline, global stall.
module vertex_transform
  import transform_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input logic               clk,
  input logic               rst_n,
  vertex_transform_if.slave bus
);

  typedef logic signed [WIDTH-1:0] elem_t;

  localparam mat4_t IDENT = mat4_identity(FRAC);

  elem_t shadow      [3:0][3:0];
  elem_t shadow_next [3:0][3:0];
  elem_t active      [3:0][3:0];

  logic enable;
  logic v1;
  logic v2;
  logic v3;

  assign enable       = !v3 || bus.ready_out;
  assign bus.ready_in = enable;
  assign bus.v_out    = v3;

  // A write in the commit cycle must land in the committed copy, so both banks load from shadow_next.
  always_comb begin
    shadow_next = shadow;
    if (bus.m_we) begin
      shadow_next[bus.m_addr[3:2]][bus.m_addr[1:0]] = bus.m_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 4; r++) begin
        for (int unsigned c = 0; c < 4; c++) begin
          shadow[2'(r)][2'(c)] <= IDENT[2'(r)][2'(c)][WIDTH-1:0];
        end
      end
    end else begin
      shadow <= shadow_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 4; r++) begin
        for (int unsigned c = 0; c < 4; c++) begin
          active[2'(r)][2'(c)] <= IDENT[2'(r)][2'(c)][WIDTH-1:0];
        end
      end
    end else if (bus.m_commit) begin
      active <= shadow_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (enable) begin
      v1 <= bus.v_in;
      v2 <= v1;
      v3 <= v2;
    end
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    elem_t row  [3:0];
    elem_t lane [3:0];
    elem_t res;
    logic  sat;

    always_comb begin
      for (int unsigned c = 0; c < 4; c++) begin
        row[2'(c)]  = active[r][2'(c)];
        lane[2'(c)] = bus.pos[2'(c)];
      end
    end

    vertex_dot4 #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_dot (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .row    (row),
      .lane   (lane),
      .result (res),
      .sat    (sat)
    );

    assign bus.new_pos[r] = res;
    assign bus.sat_out[r] = sat;
  end

endmodule
